// File: rtl/clk_trg_period_meas.sv
// -----------------------------------------------------------------------------
// clk_trg_period_meas
//
// Measures the spacing of a single-cycle trigger pulse train, for example the
// trigger output of an integer clock divider, in clk_i cycles. The result uses
// the divider-setting encoding: a trigger every N cycles reads back as N-1.
//
// Parameters:
//   CNT_WIDTH  - width of the period counter and of per_o
//   LOCK_CNT   - consecutive matching samples (after the first) for lock_o
//   LOCK_WIDTH - derived width of the lock counter, do not override
//
// Ports:
//   clk_i        in   system clock
//   rst_i        in   asynchronous active-high reset
//   en_i         in   measurement enable (level); low returns to IDLE
//   trg_i        in   trigger pulse, one cycle high per event
//   per_o        out  last measured period minus 1
//   per_valid_o  out  per_o holds an unconsumed sample
//   per_ready_i  in   consumer accepts per_o
//   lock_o       out  LOCK_CNT consecutive samples equal to their predecessor
//   drop_o       out  one-cycle pulse: an unconsumed sample was overwritten
//   ovf_o        out  sticky: counter saturated with no trigger
// -----------------------------------------------------------------------------
module clk_trg_period_meas #(
  parameter int CNT_WIDTH  = 32,
  parameter int LOCK_CNT   = 4,
  parameter int LOCK_WIDTH = $clog2(LOCK_CNT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 trg_i,
  output logic [CNT_WIDTH-1:0] per_o,
  output logic                 per_valid_o,
  input  logic                 per_ready_i,
  output logic                 lock_o,
  output logic                 drop_o,
  output logic                 ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEAS
  } state_t;

  localparam logic [LOCK_WIDTH-1:0] LP_LOCK_MAX = LOCK_WIDTH'(LOCK_CNT);

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_prev;
  logic [CNT_WIDTH-1:0]   r_per;
  logic [LOCK_WIDTH-1:0]  r_lock_cnt;
  logic [LOCK_WIDTH-1:0]  w_lock_cnt_nxt;
  logic                   r_valid;
  logic                   r_lock;
  logic                   r_drop;
  logic                   r_ovf;
  // Set when leaving ARM: the next capture has no predecessor to compare with.
  logic                   r_first;

  logic                   w_cnt_max;
  logic                   w_arm;
  logic                   w_capture;
  logic                   w_ovf_hit;

  assign w_cnt_max = &r_cnt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (!en_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_ARM;
        S_ARM:   if (trg_i) w_state_nxt = S_MEAS;
        S_MEAS:  if (!trg_i && w_cnt_max) w_state_nxt = S_ARM;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output (strobe) logic
  // ---------------------------------------------------------------------------
  // NOTE: every strobe gets a default first so no latch is inferred.
  always_comb begin
    w_arm     = 1'b0;
    w_capture = 1'b0;
    w_ovf_hit = 1'b0;
    if (en_i) begin
      case (r_state)
        S_ARM:  w_arm = trg_i;
        S_MEAS: begin
          w_capture = trg_i;
          // A trigger coinciding with all-ones is a valid capture, not overflow.
          w_ovf_hit = !trg_i && w_cnt_max;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Lock counter next value: evaluated only on captures with a predecessor,
  // saturating at LOCK_CNT; overflow discards the lock history.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_capture && !r_first) begin
      if (r_cnt == r_prev) begin
        if (r_lock_cnt != LP_LOCK_MAX) begin
          w_lock_cnt_nxt = r_lock_cnt + LOCK_WIDTH'(1);
        end
      end else begin
        w_lock_cnt_nxt = '0;
      end
    end
    if (w_ovf_hit) begin
      w_lock_cnt_nxt = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: counter, sample register, handshake, lock, drop and overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_prev     <= '0;
      r_per      <= '0;
      r_lock_cnt <= '0;
      r_valid    <= 1'b0;
      r_lock     <= 1'b0;
      r_drop     <= 1'b0;
      r_ovf      <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (!en_i) begin
        // per_o keeps its last value so software can still read it back.
        r_cnt      <= '0;
        r_lock_cnt <= '0;
        r_valid    <= 1'b0;
        r_lock     <= 1'b0;
        r_ovf      <= 1'b0;
        r_first    <= 1'b0;
      end else begin
        if (w_arm) begin
          r_cnt   <= '0;
          r_first <= 1'b1;
        end else if (w_capture) begin
          r_per   <= r_cnt;
          r_prev  <= r_cnt;
          r_cnt   <= '0;
          r_first <= 1'b0;
          r_valid <= 1'b1;
          // Overwriting a sample the consumer has not taken this cycle.
          r_drop  <= r_valid && !per_ready_i;
        end else if (w_ovf_hit) begin
          r_ovf <= 1'b1;
          r_cnt <= '0;
        end else if (r_state == S_MEAS) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end

        // A transfer empties the slot unless a capture refills it on this edge.
        if (!w_capture && r_valid && per_ready_i) begin
          r_valid <= 1'b0;
        end

        r_lock_cnt <= w_lock_cnt_nxt;
        r_lock     <= (w_lock_cnt_nxt == LP_LOCK_MAX);
      end
    end
  end

  assign per_o       = r_per;
  assign per_valid_o = r_valid;
  assign lock_o      = r_lock;
  assign drop_o      = r_drop;
  assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_clk_trg_period_meas.sv
// -----------------------------------------------------------------------------
// Testbench for clk_trg_period_meas (CNT_WIDTH=4 so overflow is reachable,
// LOCK_CNT=4). A timestamp-based reference model predicts every output; a
// compare process checks all outputs on each falling edge, and directed
// scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_clk_trg_period_meas;

  localparam int W    = 4;
  localparam int L    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         en    = 1'b0;
  logic         trg   = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] per;
  logic         valid;
  logic         lock;
  logic         drop;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  clk_trg_period_meas #(
    .CNT_WIDTH (W),
    .LOCK_CNT  (L)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .trg_i       (trg),
    .per_o       (per),
    .per_valid_o (valid),
    .per_ready_i (ready),
    .lock_o      (lock),
    .drop_o      (drop),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Phase 0: disabled/just enabled, 1: waiting for the arming
  // trigger, 2: measuring since trigger timestamp m_last. A period sample is
  // the number of edges between two triggers minus one; lock means the last
  // L+1 samples since arming are all identical.
  // ---------------------------------------------------------------------------
  int  m_cyc, m_phase, m_last, m_per, m_gap;
  bit  m_valid, m_lock, m_drop, m_ovf, m_cap;
  int  m_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_phase = 0; m_last = 0; m_per = 0;
      m_valid = 0; m_lock = 0; m_drop = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      m_cyc++;
      m_cap  = 0;
      m_drop = 0;
      if (!en) begin
        m_phase = 0; m_valid = 0; m_ovf = 0;
        m_q.delete();
      end else begin
        if (m_phase == 0) begin
          m_phase = 1;
        end else if (m_phase == 1) begin
          if (trg) begin
            m_phase = 2;
            m_last  = m_cyc;
            m_q.delete();
          end
        end else begin
          m_gap = m_cyc - m_last - 1;
          if (trg) begin
            m_cap   = 1;
            m_drop  = m_valid && !ready;
            m_per   = m_gap;
            m_valid = 1;
            m_last  = m_cyc;
            m_q.push_back(m_gap);
            if (m_q.size() > L + 1) void'(m_q.pop_front());
          end else if (m_gap == MAXV) begin
            m_ovf   = 1;
            m_phase = 1;
            m_q.delete();
          end
        end
        if (!m_cap && m_valid && ready) m_valid = 0;
      end
      m_lock = (m_q.size() == L + 1);
      foreach (m_q[i]) if (m_q[i] != m_q[0]) m_lock = 0;
    end
  end

  // Compare process: all outputs are meaningful on every cycle.
  always @(negedge clk) begin
    check("per_o",       per,   m_per & MAXV);
    check("per_valid_o", valid, m_valid);
    check("lock_o",      lock,  m_lock);
    check("drop_o",      drop,  m_drop);
    check("ovf_o",       ovf,   m_ovf);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input bit e, input bit t);
    en  = e;
    trg = t;
    @(posedge clk);
    #2;
  endtask

  task automatic train(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      tick(1'b1, 1'b1);
      for (int j = 1; j < p; j++) tick(1'b1, 1'b0);
    end
  endtask

  task automatic random_phase(input int bursts);
    for (int b = 0; b < bursts; b++) begin
      int p = $urandom_range(1, 19);
      int n = $urandom_range(1, 7);
      for (int k = 0; k < n; k++) begin
        for (int j = 0; j < p; j++) begin
          ready = ($urandom_range(0, 2) != 0);
          tick(($urandom_range(0, 60) != 0), (j == 0));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("reset per_o",  per,   0);
    check("reset valid",  valid, 0);
    check("reset lock",   lock,  0);
    check("reset ovf",    ovf,   0);
    rst = 1'b0;

    // Steady period 4 with a ready consumer: lock on the 6th pulse.
    ready = 1'b1;
    tick(1'b1, 1'b0);
    train(4, 6);
    check("p4 per_o", per, 3);
    check("p4 lock",  lock, 1);

    // One period of 6 breaks lock, then 4 matching samples of period 4 restore it.
    repeat (2) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("p6 per_o", per, 5);
    check("p6 lock",  lock, 0);
    repeat (3) tick(1'b1, 1'b0);
    train(4, 5);
    check("relock per_o", per, 3);
    check("relock lock",  lock, 1);

    // Stalled consumer, period 3: held sample and drop pulses.
    ready = 1'b0;
    train(3, 5);
    check("stall per_o", per, 2);
    check("stall valid", valid, 1);
    ready = 1'b1;
    tick(1'b1, 1'b1);
    check("xfer+cap drop",  drop, 0);
    check("xfer+cap valid", valid, 1);
    check("xfer+cap per_o", per, 2);

    // Overflow: one trigger then silence.
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (20) tick(1'b1, 1'b0);
    check("ovf set",  ovf, 1);
    check("ovf lock", lock, 0);
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("post-ovf per_o", per, 4);
    check("post-ovf ovf",   ovf, 1);
    tick(1'b0, 1'b0);
    check("disable ovf",   ovf, 0);
    check("disable per_o", per, 4);
    check("disable valid", valid, 0);

    // Largest capturable period: trigger exactly at all-ones is not overflow.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (15) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("max per_o", per, MAXV);
    check("max ovf",   ovf, 0);

    // Back-to-back triggers from ARM.
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("arm no sample", valid, 0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    check("b2b per_o", per, 0);

    // Asynchronous reset in MEAS with a pending sample.
    ready = 1'b0;
    train(5, 3);
    rst = 1'b1;
    #1;
    check("async per_o", per,   0);
    check("async valid", valid, 0);
    check("async lock",  lock,  0);
    check("async ovf",   ovf,   0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    check("rst 1st trg valid", valid, 0);
    tick(1'b1, 1'b1);
    check("rst 2nd trg valid", valid, 1);
    check("rst 2nd trg per_o", per, 3);

    // Randomized traffic checked by the model.
    random_phase(80);
    tick(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
